// File: rtl/child_sequencer.sv
// rtl/child_sequencer.sv - start/done sequencer for a fixed group of child units
// Runs each enabled child once, in ascending index order, with a per-child watchdog.
module child_sequencer #(
   parameter int N_CHILD = 5,
   parameter int TIMEOUT = 200,
   localparam int IW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [N_CHILD-1:0] enable_mask_i,
   input  logic [N_CHILD-1:0] child_done_i,
   output logic [N_CHILD-1:0] child_start_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [IW-1:0]      err_idx_o
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [N_CHILD-1:0] mask_q, mask_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               error_q, error_d;
   logic [IW-1:0]      err_idx_q, err_idx_d;

   logic [IW-1:0]      first_idx;
   logic [IW-1:0]      next_idx;
   logic               next_found;

   // Priority searches: lowest set bit of the incoming mask, and the lowest
   // latched mask bit strictly above the current child.
   always_comb begin
      first_idx  = '0;
      next_idx   = '0;
      next_found = 1'b0;
      for (int i = N_CHILD - 1; i >= 0; i--) begin
         if (enable_mask_i[i]) begin
            first_idx = IW'(i);
         end
         if (mask_q[i] && (i > int'(idx_q))) begin
            next_idx   = IW'(i);
            next_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         mask_q    <= '0;
         timer_q   <= '0;
         error_q   <= 1'b0;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mask_q    <= mask_d;
         timer_q   <= timer_d;
         error_q   <= error_d;
         err_idx_q <= err_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mask_d    = mask_q;
      timer_d   = timer_q;
      error_d   = error_q;
      err_idx_d = err_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mask_d  = enable_mask_i;
               error_d = 1'b0;
               if (|enable_mask_i) begin
                  idx_d   = first_idx;
                  state_d = S_LAUNCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LAUNCH: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // A done arriving on the final watchdog cycle still counts.
            if (child_done_i[idx_q]) begin
               state_d = S_NEXT;
            end else if (timer_q == TIMER_LAST) begin
               error_d   = 1'b1;
               err_idx_d = idx_q;
               state_d   = S_DONE;
            end
         end
         S_NEXT: begin
            if (next_found) begin
               idx_d   = next_idx;
               state_d = S_LAUNCH;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      child_start_o = '0;
      if (state_q == S_LAUNCH) begin
         child_start_o[idx_q] = 1'b1;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_DONE);
   assign error_o   = error_q;
   assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_child_sequencer.sv
// tb/tb_child_sequencer.sv - self-checking bench for child_sequencer
// Random sequences are compared against a cycle-schedule model built from the start/done rules.
module tb_child_sequencer;

   localparam int N  = 5;
   localparam int TO = 200;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [N-1:0] enable_mask_i = '0;
   logic [N-1:0] child_done_i = '0;
   logic [N-1:0] child_start_o;
   logic         busy_o;
   logic         done_o;
   logic         error_o;
   logic [2:0]   err_idx_o;

   int tests = 0;
   int fails = 0;
   int lat_g [N];

   always #5 clk = ~clk;

   child_sequencer #(.N_CHILD(N), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .enable_mask_i (enable_mask_i),
      .child_done_i  (child_done_i),
      .child_start_o (child_start_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .err_idx_o     (err_idx_o)
   );

   // lat_g[i]: cycles from child i's start pulse to its done pulse; 0 = never answers.
   task automatic run_seq(input logic [N-1:0] mask, input bit stray, input string name);
      int exp_st [N];
      int st_cnt [N];
      int st_cyc [N];
      int due [N];
      bit waiting [N];
      int c, exp_done, exp_eidx, done_cyc, done_cnt, busy_cnt, multi;
      bit exp_err;
      logic err_at1;
      logic [N-1:0] d, r;
      c = 1;
      exp_err = 1'b0;
      exp_eidx = 0;
      for (int i = 0; i < N; i++) begin
         exp_st[i] = -1; st_cnt[i] = 0; st_cyc[i] = -1; due[i] = -1; waiting[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (mask[i] && !exp_err) begin
            exp_st[i] = c;
            if (lat_g[i] >= 1 && lat_g[i] <= TO) begin
               c = c + lat_g[i] + 2;
            end else begin
               exp_err = 1'b1;
               exp_eidx = i;
               c = c + TO + 1;
            end
         end
      end
      exp_done = c;

      done_cyc = -1; done_cnt = 0; busy_cnt = 0; multi = 0; err_at1 = 1'bx;
      for (int rel = 0; rel <= exp_done + 3; rel++) begin
         d = '0;
         for (int j = 0; j < N; j++) begin
            if (waiting[j] && due[j] == rel) begin
               d[j] = 1'b1;
               waiting[j] = 1'b0;
            end
         end
         if (stray) begin
            r = N'($urandom);
            for (int j = 0; j < N; j++) if (waiting[j]) r[j] = 1'b0;
            d = d | r;
         end
         child_done_i = d;
         if (rel == 0) begin
            start_i = 1'b1;
            enable_mask_i = mask;
         end else begin
            start_i = (stray && rel <= exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            enable_mask_i = stray ? N'($urandom) : mask;
         end
         @(negedge clk);
         if ($countones(child_start_o) > 1) multi++;
         for (int j = 0; j < N; j++) begin
            if (child_start_o[j]) begin
               st_cnt[j]++;
               if (st_cyc[j] < 0) st_cyc[j] = rel;
               if (lat_g[j] >= 1) due[j] = rel + lat_g[j];
               waiting[j] = 1'b1;
            end
         end
         if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = rel;
         end
         if (busy_o) busy_cnt++;
         if (rel == 1) err_at1 = error_o;
         @(posedge clk);
         #1;
      end
      start_i = 1'b0;
      child_done_i = '0;

      for (int j = 0; j < N; j++) begin
         tests++;
         if (st_cnt[j] !== ((exp_st[j] >= 0) ? 1 : 0) || st_cyc[j] !== exp_st[j]) begin
            fails++;
            $display("FAIL %s start_child%0d: got count=%0d cycle=%0d, want count=%0d cycle=%0d",
                     name, j, st_cnt[j], st_cyc[j], (exp_st[j] >= 0) ? 1 : 0, exp_st[j]);
         end
      end
      tests++;
      if (done_cyc !== exp_done || done_cnt !== 1) begin
         fails++;
         $display("FAIL %s done_pulse: got cycle=%0d count=%0d, want cycle=%0d count=1",
                  name, done_cyc, done_cnt, exp_done);
      end
      tests++;
      if (busy_cnt !== exp_done) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d, want %0d", name, busy_cnt, exp_done);
      end
      tests++;
      if (multi !== 0) begin
         fails++;
         $display("FAIL %s start_overlap: got %0d multi-hot cycles, want 0", name, multi);
      end
      tests++;
      if (err_at1 !== 1'b0) begin
         fails++;
         $display("FAIL %s error_cleared_on_start: got %b, want 0", name, err_at1);
      end
      tests++;
      if (error_o !== exp_err) begin
         fails++;
         $display("FAIL %s error_final: got %b, want %b", name, error_o, exp_err);
      end
      if (exp_err) begin
         tests++;
         if (err_idx_o !== 3'(exp_eidx)) begin
            fails++;
            $display("FAIL %s err_idx: got %0d, want %0d", name, err_idx_o, exp_eidx);
         end
      end
   endtask

   task automatic set_lat(input int v);
      for (int i = 0; i < N; i++) lat_g[i] = v;
   endtask

   task automatic check_zero_outputs(input string name);
      tests++;
      if (child_start_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          error_o !== 1'b0 || err_idx_o !== 3'd0) begin
         fails++;
         $display("FAIL %s: got start=%b busy=%b done=%b err=%b idx=%0d, want all 0",
                  name, child_start_o, busy_o, done_o, error_o, err_idx_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset_values");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_run();
      set_lat(3);
      run_seq(5'b11111, 1'b0, "full_run");
   endtask

   task automatic test_sparse();
      for (int i = 0; i < N; i++) lat_g[i] = $urandom_range(1, 9);
      run_seq(5'b10010, 1'b0, "sparse");
   endtask

   task automatic test_zero_mask();
      set_lat(2);
      run_seq(5'b00000, 1'b0, "zero_mask");
   endtask

   task automatic test_timeout();
      set_lat(3);
      lat_g[2] = 0;
      run_seq(5'b11111, 1'b0, "timeout");
   endtask

   task automatic test_error_clear();
      set_lat(4);
      run_seq(5'b01011, 1'b0, "error_clear");
   endtask

   task automatic test_stray_and_coincident();
      for (int i = 0; i < N; i++) lat_g[i] = $urandom_range(1, 6);
      lat_g[4] = TO;
      run_seq(5'b11101, 1'b1, "stray_coincident");
      for (int i = 0; i < N; i++) lat_g[i] = $urandom_range(1, 6);
      lat_g[1] = TO + 1;
      run_seq(5'b00110, 1'b1, "stray_late_done");
   endtask

   task automatic test_reset_async();
      bit seen;
      int pulses;
      set_lat(3);
      run_seq(5'b10100, 1'b0, "pre_reset");
      lat_g[0] = 0;
      run_seq(5'b00001, 1'b0, "pre_reset_abort");
      seen = 1'b0;
      child_done_i = 5'b00001;
      start_i = 1'b1;
      enable_mask_i = 5'b11111;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (child_start_o[1]) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL reset_async_setup: got no start on child 1, want one within 40 cycles");
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("reset_async_immediate");
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (child_start_o !== '0 || busy_o !== 1'b0) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL reset_async_hold: got %0d active cycles in reset, want 0", pulses);
      end
      child_done_i = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_lat(2);
      run_seq(5'b11111, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic [N-1:0] m;
      for (int n = 0; n < 6; n++) begin
         m = N'($urandom);
         for (int i = 0; i < N; i++) lat_g[i] = $urandom_range(1, 10);
         run_seq(m, n[0], "random");
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_sparse();
      test_zero_mask();
      test_timeout();
      test_error_clear();
      test_stray_and_coincident();
      test_reset_async();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
